// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one pulse-strobed memory port between fetch and data requesters
// with a starvation guard that forces fetch through after STARVE_LIMIT consecutive data wins.
module mem_port_arbiter #(
    parameter int WIDTH        = 8,
    parameter int STARVE_LIMIT = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             f_req,
    input  logic [WIDTH-1:0] f_addr,
    output logic             f_ack,
    output logic [WIDTH-1:0] f_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_ack,
    output logic [WIDTH-1:0] d_rdata,
    output logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] to_mem,
    input  logic [WIDTH-1:0] from_mem,
    output logic             mem_clock,
    output logic             mem_write,
    output logic             busy,
    output logic             grant_data
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_t;
    state_t     state;
    logic [3:0] sc;
    logic       pick_data;
    assign pick_data = d_req && (!f_req || sc < 4'(STARVE_LIMIT));
    assign busy      = state != IDLE;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sc         <= '0;
            f_ack      <= 1'b0;
            d_ack      <= 1'b0;
            f_rdata    <= '0;
            d_rdata    <= '0;
            address    <= '0;
            to_mem     <= '0;
            mem_clock  <= 1'b0;
            mem_write  <= 1'b0;
            grant_data <= 1'b0;
        end else begin
            f_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE, ACK: begin
                    if (f_req || d_req) begin
                        state      <= SETUP;
                        grant_data <= pick_data;
                        address    <= pick_data ? d_addr : f_addr;
                        to_mem     <= pick_data ? d_wdata : to_mem;
                        mem_write  <= pick_data && d_we;
                        // a data win with fetch waiting can only happen below the limit
                        sc         <= pick_data ? (f_req ? sc + 4'd1 : sc) : 4'd0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SETUP: begin
                    state     <= STROBE;
                    mem_clock <= 1'b1;
                end
                STROBE: begin
                    state     <= ACK;
                    mem_clock <= 1'b0;
                    mem_write <= 1'b0;
                    if (!mem_write && grant_data) d_rdata <= from_mem;
                    if (!mem_write && !grant_data) f_rdata <= from_mem;
                    d_ack     <= grant_data;
                    f_ack     <= !grant_data;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, strobe sequencing, starvation and reset.
module tb_mem_port_arbiter;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [7:0] f_addr = '0, d_addr = '0, d_wdata = '0;
    logic       f_ack, d_ack, mem_clock, mem_write, busy, grant_data;
    logic [7:0] f_rdata, d_rdata, address, to_mem;
    logic [7:0] from_mem = '0;
    bit   [7:0] mem [256];
    bit         wr  [256];
    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.WIDTH(8), .STARVE_LIMIT(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .address(address), .to_mem(to_mem), .from_mem(from_mem),
        .mem_clock(mem_clock), .mem_write(mem_write),
        .busy(busy), .grant_data(grant_data)
    );

    always #5 clock = ~clock;

    // memory preloaded with 0xA7 at 0x05, zero elsewhere until written
    always @(posedge mem_clock) begin
        if (mem_write) begin
            mem[address] <= to_mem;
            wr[address]  <= 1'b1;
        end else begin
            from_mem <= wr[address] ? mem[address] : (address == 8'h05 ? 8'hA7 : 8'h00);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #1;
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_mclk", 16'(mem_clock), 16'h0);
        chk("rst_frd", 16'(f_rdata), 16'h0);
        chk("rst_drd", 16'(d_rdata), 16'h0);
        chk("rst_addr", 16'(address), 16'h0);
        chk("rst_gd", 16'(grant_data), 16'h0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // single fetch
        f_req = 1'b1; f_addr = 8'h05;
        tick();
        chk("f1_busy", 16'(busy), 16'h1);
        chk("f1_setup_mclk", 16'(mem_clock), 16'h0);
        chk("f1_addr", 16'(address), 16'h05);
        chk("f1_gd", 16'(grant_data), 16'h0);
        chk("f1_we", 16'(mem_write), 16'h0);
        tick();
        chk("f1_strobe_mclk", 16'(mem_clock), 16'h1);
        chk("f1_strobe_ack", 16'(f_ack), 16'h0);
        tick();
        chk("f1_ack", 16'(f_ack), 16'h1);
        chk("f1_rdata", 16'(f_rdata), 16'hA7);
        chk("f1_ack_mclk", 16'(mem_clock), 16'h0);
        chk("f1_ack_we", 16'(mem_write), 16'h0);
        f_req = 1'b0;
        tick();
        chk("f1_ack_drop", 16'(f_ack), 16'h0);
        chk("f1_idle", 16'(busy), 16'h0);

        // store 0x3C to 0x10
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 8'h3C;
        tick();
        chk("st_setup_we", 16'(mem_write), 16'h1);
        chk("st_gd", 16'(grant_data), 16'h1);
        chk("st_tomem", 16'(to_mem), 16'h3C);
        tick();
        chk("st_strobe_we", 16'(mem_write), 16'h1);
        chk("st_strobe_mclk", 16'(mem_clock), 16'h1);
        tick();
        chk("st_ack", 16'(d_ack), 16'h1);
        chk("st_drd", 16'(d_rdata), 16'h00);
        chk("st_ack_we", 16'(mem_write), 16'h0);
        d_req = 1'b0;
        tick();
        chk("st_mem10", 16'(mem[8'h10]), 16'h3C);
        chk("st_idle", 16'(busy), 16'h0);

        // store 0x99 to 0x20, then simultaneous load of 0x20 and fetch
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h99;
        tick(); tick(); tick();
        chk("st2_ack", 16'(d_ack), 16'h1);
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b0; f_req = 1'b1; f_addr = 8'h05;
        tick();
        chk("sim_gd", 16'(grant_data), 16'h1);
        tick(); tick();
        chk("sim_dack", 16'(d_ack), 16'h1);
        chk("sim_fack0", 16'(f_ack), 16'h0);
        chk("sim_drd", 16'(d_rdata), 16'h99);
        d_req = 1'b0;
        tick();
        chk("sim_fgrant", 16'(grant_data), 16'h0);
        tick();
        chk("sim_fack_early", 16'(f_ack), 16'h0);
        tick();
        chk("sim_fack", 16'(f_ack), 16'h1);
        f_req = 1'b0;
        tick();
        chk("sim_idle", 16'(busy), 16'h0);

        // both held continuously: D D F D D F, acks every third cycle
        f_req = 1'b1; f_addr = 8'h05; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
        for (int k = 0; k < 6; k++) begin
            logic exp_d;
            exp_d = (k % 3) != 2;
            tick();
            chk($sformatf("stv%0d_gd", k), 16'(grant_data), 16'(exp_d));
            chk($sformatf("stv%0d_noack", k), 16'(f_ack | d_ack), 16'h0);
            tick();
            chk($sformatf("stv%0d_noack2", k), 16'(f_ack | d_ack), 16'h0);
            tick();
            chk($sformatf("stv%0d_dack", k), 16'(d_ack), 16'(exp_d));
            chk($sformatf("stv%0d_fack", k), 16'(f_ack), 16'(!exp_d));
        end
        chk("stv_drd", 16'(d_rdata), 16'h3C);
        chk("stv_frd", 16'(f_rdata), 16'hA7);
        f_req = 1'b0; d_req = 1'b0;
        tick();

        // reset during strobe of a fetch
        f_req = 1'b1; f_addr = 8'h10;
        tick(); tick();
        chk("rs_strobe", 16'(mem_clock), 16'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("rs_mclk", 16'(mem_clock), 16'h0);
        chk("rs_busy", 16'(busy), 16'h0);
        chk("rs_frd", 16'(f_rdata), 16'h00);
        tick();
        chk("rs_noack", 16'(f_ack), 16'h0);
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("rs_ack", 16'(f_ack), 16'h1);
        chk("rs_rdata", 16'(f_rdata), 16'h3C);
        f_req = 1'b0;
        tick();

        // data req dropped in setup; fetch waits until after ack
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
        tick();
        d_req = 1'b0; d_addr = 8'h10; f_req = 1'b1; f_addr = 8'h05;
        tick();
        chk("dr_noack", 16'(d_ack), 16'h0);
        tick();
        chk("dr_dack", 16'(d_ack), 16'h1);
        chk("dr_drd", 16'(d_rdata), 16'h99);
        chk("dr_gd", 16'(grant_data), 16'h1);
        tick();
        chk("dr_fgrant", 16'(grant_data), 16'h0);
        chk("dr_faddr", 16'(address), 16'h05);
        tick(); tick();
        chk("dr_fack", 16'(f_ack), 16'h1);
        f_req = 1'b0;
        tick();
        chk("dr_idle", 16'(busy), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single pulse-clocked memory port between the instruction-fetch requester and the load/store (data) requester of the controller.
- Each requester uses a req/ack handshake.
- The arbiter latches the winning request and sequences the memory strobe (`address`, `to_mem`, `mem_write`, then a `mem_clock` pulse), capturing read data afterwards.
- Data accesses win by default; a starvation guard forces a fetch grant after `STARVE_LIMIT` consecutive data wins.

Parameters:
- `WIDTH`, default 8: address and data width.
- `STARVE_LIMIT`, default 2: consecutive data grants (while fetch waits) before fetch is forced through; legal range 1..15.

Ports:
- `clock` in 1: system clock; all state updates on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `f_req` in 1: fetch request; hold high until `f_ack`.
- `f_addr` in WIDTH: fetch address; stable while `f_req` is high.
- `f_ack` out 1: one-cycle pulse; fetch complete, `f_rdata` valid.
- `f_rdata` out WIDTH: last fetched word.
- `d_req` in 1: data request; hold high until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in WIDTH: data address.
- `d_wdata` in WIDTH: store data.
- `d_ack` out 1: one-cycle pulse; data access complete.
- `d_rdata` out WIDTH: last loaded word.
- `address` out WIDTH: memory address.
- `to_mem` out WIDTH: memory write data.
- `from_mem` in WIDTH: memory read data; valid after the `mem_clock` rising edge.
- `mem_clock` out 1: memory strobe; memory acts on its rising edge.
- `mem_write` out 1: memory write enable.
- `busy` out 1: high in any state other than IDLE.
- `grant_data` out 1: owner of the current or last transaction (1 = data, 0 = fetch).

Behaviour:
- Reset (async, `reset_n` = 0):
  - State goes to IDLE.
  - All outputs go to 0, including `mem_clock`, which drops immediately.
  - Starvation counter `sc` goes to 0.
  - Reset mid-transaction aborts it: no ack, no rdata update.
- States: IDLE, SETUP, STROBE, ACK. All transitions happen on posedge `clock`.
- IDLE:
  - If any request is present, arbitrate and latch the winner's address, we and wdata into `address`, `mem_write` (0 for fetch) and `to_mem`.
  - Set `grant_data` and go to SETUP.
  - With no request, stay in IDLE.
- SETUP: `mem_clock` = 0, outputs stable. Go to STROBE and set `mem_clock` = 1.
- STROBE: set `mem_clock` = 0 and `mem_write` = 0. On a read, capture `from_mem` into `f_rdata` or `d_rdata` according to the owner. Raise the owner's ack and go to ACK.
- ACK:
  - Ack is high for exactly this cycle and drops on the next edge.
  - On that edge, arbitrate again. If any req is high, latch and go straight to SETUP (back-to-back); otherwise go to IDLE.
  - A requester still asserting req on that edge issues a new request. Requesters deassert req during their ack cycle when they have no further access.
- Latency and throughput:
  - A request sampled in IDLE at edge N produces its ack high during the cycle after edge N+2.
  - Sustained throughput is one access per 3 cycles.
- Arbitration, when both requesters are high:
  - Data wins if `sc` < `STARVE_LIMIT`; otherwise fetch wins.
  - A single requester always wins.
- Starvation counter `sc` (4-bit, saturating at `STARVE_LIMIT`):
  - Cleared on any fetch grant.
  - Incremented on a data grant made while `f_req` is high.
  - Unchanged on a data grant with `f_req` low.
- Output holding:
  - `address` and `to_mem` hold their latched values after completion until the next latch.
  - A store does not modify `d_rdata`. A fetch does not modify `d_rdata`, and vice versa.
- A req dropped before its ack does not abort the latched transaction; it completes and the ack still pulses.
- A req arriving during a transaction waits and is not lost.
- The input bundle is sampled only at the latch edge; later changes to the inputs are ignored.
- `mem_clock` is never high for more than one clock cycle and is never high in IDLE or ACK.
- `mem_write` is high only in SETUP and STROBE of a store.

Test Plan:
- Reset, then `f_req` = 1 with `f_addr` = 0x05 and memory[5] = 0xA7 → SETUP → STROBE (`mem_clock` = 1 for one cycle) → `f_ack` one cycle later with `f_rdata` = 0xA7; `mem_write` stays 0 throughout.
- Store: `d_req` = 1, `d_we` = 1, `d_addr` = 0x10, `d_wdata` = 0x3C → `mem_write` = 1 in SETUP and STROBE, memory[0x10] = 0x3C, `d_ack` pulses, `d_rdata` unchanged (0x00).
- `f_req` and `d_req` held continuously with `STARVE_LIMIT` = 2 → grant order data, data, fetch, data, data, fetch; acks exactly 3 cycles apart.
- Simultaneous requests where the load follows a store to 0x20 with value 0x99 → data served first with `d_rdata` = 0x99; fetch acked 3 cycles after `d_ack`.
- `reset_n` pulsed low during STROBE of a fetch → `mem_clock` drops asynchronously, no `f_ack`, `f_rdata` = 0, `busy` = 0; after release a new request completes normally.
- `d_req` dropped in SETUP → access still completes and `d_ack` pulses; the next `f_req` is granted only after ACK.
